// File: rtl/ivector_queue.sv
// ivector_queue: small FIFO that accepts paired (meth, v) requests on the say
// port and re-issues them in order as heard indications when the respond rule
// is enabled. Tracks occupancy and a wrapping count of delivered indications.
module ivector_queue #(
  parameter int WIDTH = 192,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     say__ENA,
  input  logic [WIDTH-1:0]         say_meth,
  input  logic [WIDTH-1:0]         say_v,
  output logic                     say__RDY,
  output logic                     ind_heard__ENA,
  output logic [WIDTH-1:0]         ind_heard_heard_meth,
  output logic [WIDTH-1:0]         ind_heard_heard_v,
  input  logic                     ind_heard__RDY,
  input  logic                     rule_enable,
  output logic                     rule_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNTW-1:0]          delivered
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [CNTW-1:0] DLV_ONE  = CNTW'(1);

  // Entry storage: meth in the upper half, v in the lower half.
  logic [2*WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]   head_reg, head_next;
  logic [AW-1:0]   tail_reg, tail_next;
  logic [AW:0]     count_reg, count_next;
  logic [CNTW-1:0] delivered_reg, delivered_next;
  // Held low through reset so say__RDY stays low until the first clock after release.
  logic            live_reg;

  logic            enq;
  logic            deq;
  logic [2*WIDTH-1:0] head_entry;

  // Handshake decode; readiness depends on registered state only.
  assign say__RDY       = live_reg && (count_reg != FULL_CNT);
  assign rule_ready     = (count_reg != '0) && ind_heard__RDY;
  assign ind_heard__ENA = rule_enable && rule_ready;
  assign enq            = say__ENA && say__RDY;
  assign deq            = ind_heard__ENA;

  assign head_entry           = mem[head_reg];
  assign ind_heard_heard_meth = (count_reg != '0) ? head_entry[2*WIDTH-1:WIDTH] : '0;
  assign ind_heard_heard_v    = (count_reg != '0) ? head_entry[WIDTH-1:0]       : '0;

  assign count     = count_reg;
  assign delivered = delivered_reg;

  // Next-state for pointers, occupancy and the delivered counter.
  always_comb begin
    head_next      = head_reg;
    tail_next      = tail_reg;
    count_next     = count_reg;
    delivered_next = delivered_reg;
    if (enq) begin
      tail_next = tail_reg + PTR_ONE;
    end
    if (deq) begin
      head_next      = head_reg + PTR_ONE;
      delivered_next = delivered_reg + DLV_ONE;
    end
    case ({enq, deq})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      delivered_reg <= '0;
      live_reg      <= 1'b0;
    end else begin
      head_reg      <= head_next;
      tail_reg      <= tail_next;
      count_reg     <= count_next;
      delivered_reg <= delivered_next;
      live_reg      <= 1'b1;
    end
  end

  // Storage write at the tail; contents need no reset since count gates visibility.
  always_ff @(posedge CLK) begin
    if (enq) begin
      mem[tail_reg] <= {say_meth, say_v};
    end
  end

endmodule

// File: tb/tb_ivector_queue.sv
// Directed bench for ivector_queue: reset, single transfer, fill/overflow,
// full-with-respond, toggled-enable stream, mid-stream reset, counter wrap.
module tb_ivector_queue;

  localparam int WIDTH = 192;
  localparam int DEPTH = 4;
  localparam int CNTW  = 4;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              say__ENA;
  logic [WIDTH-1:0]  say_meth;
  logic [WIDTH-1:0]  say_v;
  logic              say__RDY;
  logic              ind_heard__ENA;
  logic [WIDTH-1:0]  ind_heard_heard_meth;
  logic [WIDTH-1:0]  ind_heard_heard_v;
  logic              ind_heard__RDY;
  logic              rule_enable;
  logic              rule_ready;
  logic [2:0]        count;
  logic [CNTW-1:0]   delivered;

  int errors = 0;
  int checks = 0;

  ivector_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .CLK                  (CLK),
    .nRST                 (nRST),
    .say__ENA             (say__ENA),
    .say_meth             (say_meth),
    .say_v                (say_v),
    .say__RDY             (say__RDY),
    .ind_heard__ENA       (ind_heard__ENA),
    .ind_heard_heard_meth (ind_heard_heard_meth),
    .ind_heard_heard_v    (ind_heard_heard_v),
    .ind_heard__RDY       (ind_heard__RDY),
    .rule_enable          (rule_enable),
    .rule_ready           (rule_ready),
    .count                (count),
    .delivered            (delivered)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    say__ENA       = 1'b0;
    say_meth       = '0;
    say_v          = '0;
    rule_enable    = 1'b0;
    ind_heard__RDY = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rule_enable    = 1'b1;
    ind_heard__RDY = 1'b1;
    nRST = 1'b1;
    #1 nRST = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (delivered !== 4'd0) begin errors++; $display("FAIL reset_delivered got=%0d exp=0", delivered); end
    checks++; if (say__RDY !== 1'b0) begin errors++; $display("FAIL reset_say_rdy got=%b exp=0", say__RDY); end
    checks++; if (ind_heard__ENA !== 1'b0) begin errors++; $display("FAIL reset_ind_ena got=%b exp=0", ind_heard__ENA); end
    tick();
    nRST = 1'b1;
    #1;
    checks++; if (say__RDY !== 1'b0) begin errors++; $display("FAIL release_say_rdy_preclk got=%b exp=0", say__RDY); end
    tick();
    checks++; if (say__RDY !== 1'b1) begin errors++; $display("FAIL release_say_rdy got=%b exp=1", say__RDY); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL release_count got=%0d exp=0", count); end
    $display("reset: count=%0d delivered=%0d say_rdy=%b", count, delivered, say__RDY);
  endtask

  task automatic test_basic();
    say__ENA = 1'b1; say_meth = WIDTH'(1); say_v = WIDTH'(2);
    rule_enable = 1'b1; ind_heard__RDY = 1'b1;
    #1;
    checks++; if (ind_heard__ENA !== 1'b0) begin errors++; $display("FAIL basic_no_bypass got=%b exp=0", ind_heard__ENA); end
    tick();
    say__ENA = 1'b0;
    #1;
    checks++; if (ind_heard__ENA !== 1'b1) begin errors++; $display("FAIL basic_ena got=%b exp=1", ind_heard__ENA); end
    checks++; if (ind_heard_heard_meth !== WIDTH'(1)) begin errors++; $display("FAIL basic_meth got=%0h exp=1", ind_heard_heard_meth); end
    checks++; if (ind_heard_heard_v !== WIDTH'(2)) begin errors++; $display("FAIL basic_v got=%0h exp=2", ind_heard_heard_v); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL basic_count1 got=%0d exp=1", count); end
    tick();
    checks++; if (delivered !== 4'd1) begin errors++; $display("FAIL basic_delivered got=%0d exp=1", delivered); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL basic_count0 got=%0d exp=0", count); end
    checks++; if (ind_heard__ENA !== 1'b0) begin errors++; $display("FAIL basic_ena_after got=%b exp=0", ind_heard__ENA); end
    checks++; if (ind_heard_heard_meth !== '0) begin errors++; $display("FAIL basic_empty_meth got=%0h exp=0", ind_heard_heard_meth); end
    $display("basic: delivered=%0d count=%0d", delivered, count);
  endtask

  task automatic test_fill();
    logic exp_rdy;
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      say__ENA = 1'b1; say_meth = WIDTH'(10 + i); say_v = WIDTH'(20 + i);
      #1;
      exp_rdy = (i < 4);
      checks++; if (say__RDY !== exp_rdy) begin errors++; $display("FAIL fill_rdy[%0d] got=%b exp=%b", i, say__RDY, exp_rdy); end
      $display("fill: push %0d rdy=%b count=%0d", i, say__RDY, count);
      tick();
    end
    say__ENA = 1'b0;
    #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
    checks++; if (say__RDY !== 1'b0) begin errors++; $display("FAIL fill_full_rdy got=%b exp=0", say__RDY); end
    checks++; if (rule_ready !== 1'b0) begin errors++; $display("FAIL fill_rule_ready got=%b exp=0", rule_ready); end
    checks++; if (ind_heard_heard_meth !== WIDTH'(10)) begin errors++; $display("FAIL fill_head_meth got=%0d exp=10", ind_heard_heard_meth); end
    checks++; if (ind_heard_heard_v !== WIDTH'(20)) begin errors++; $display("FAIL fill_head_v got=%0d exp=20", ind_heard_heard_v); end
  endtask

  task automatic test_full_respond();
    logic [WIDTH-1:0] exp_m [4];
    logic [WIDTH-1:0] exp_v [4];
    exp_m[0] = WIDTH'(11); exp_m[1] = WIDTH'(12); exp_m[2] = WIDTH'(13); exp_m[3] = WIDTH'(99);
    exp_v[0] = WIDTH'(21); exp_v[1] = WIDTH'(22); exp_v[2] = WIDTH'(23); exp_v[3] = WIDTH'(98);
    say__ENA = 1'b1; say_meth = WIDTH'(99); say_v = WIDTH'(98);
    rule_enable = 1'b1; ind_heard__RDY = 1'b1;
    #1;
    checks++; if (say__RDY !== 1'b0) begin errors++; $display("FAIL full_rsp_rdy got=%b exp=0", say__RDY); end
    checks++; if (ind_heard__ENA !== 1'b1) begin errors++; $display("FAIL full_rsp_ena got=%b exp=1", ind_heard__ENA); end
    checks++; if (ind_heard_heard_meth !== WIDTH'(10)) begin errors++; $display("FAIL full_rsp_meth got=%0d exp=10", ind_heard_heard_meth); end
    tick();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_rsp_count3 got=%0d exp=3", count); end
    rule_enable = 1'b0;
    #1;
    checks++; if (say__RDY !== 1'b1) begin errors++; $display("FAIL full_rsp_rdy_next got=%b exp=1", say__RDY); end
    tick();
    say__ENA = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_rsp_count4 got=%0d exp=4", count); end
    rule_enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (ind_heard__ENA !== 1'b1) begin errors++; $display("FAIL drain_ena[%0d] got=%b exp=1", k, ind_heard__ENA); end
      checks++; if (ind_heard_heard_meth !== exp_m[k]) begin errors++; $display("FAIL drain_meth[%0d] got=%0d exp=%0d", k, ind_heard_heard_meth, exp_m[k]); end
      checks++; if (ind_heard_heard_v !== exp_v[k]) begin errors++; $display("FAIL drain_v[%0d] got=%0d exp=%0d", k, ind_heard_heard_v, exp_v[k]); end
      $display("drain: pop meth=%0d v=%0d", ind_heard_heard_meth, ind_heard_heard_v);
      tick();
    end
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", count); end
    checks++; if (ind_heard__ENA !== 1'b0) begin errors++; $display("FAIL drain_ena_empty got=%b exp=0", ind_heard__ENA); end
    checks++; if (delivered !== 4'd6) begin errors++; $display("FAIL drain_delivered got=%0d exp=6", delivered); end
  endtask

  task automatic test_stream();
    logic [2*WIDTH-1:0] q[$];
    logic [3:0] exp_dlv;
    logic exp_rdy, exp_ena;
    exp_dlv = 4'd6;
    idle_inputs();
    ind_heard__RDY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      say__ENA = 1'b1; say_meth = WIDTH'(50 + i); say_v = WIDTH'(150 + i);
      rule_enable = ((i % 2) == 1);
      #1;
      exp_rdy = (q.size() != DEPTH);
      exp_ena = rule_enable && (q.size() != 0);
      checks++; if (say__RDY !== exp_rdy) begin errors++; $display("FAIL stream_rdy[%0d] got=%b exp=%b", i, say__RDY, exp_rdy); end
      checks++; if (ind_heard__ENA !== exp_ena) begin errors++; $display("FAIL stream_ena[%0d] got=%b exp=%b", i, ind_heard__ENA, exp_ena); end
      if (exp_ena) begin
        checks++; if ({ind_heard_heard_meth, ind_heard_heard_v} !== q[0]) begin errors++; $display("FAIL stream_data[%0d] got meth=%0d v=%0d exp meth=%0d v=%0d", i, ind_heard_heard_meth, ind_heard_heard_v, q[0][2*WIDTH-1:WIDTH], q[0][WIDTH-1:0]); end
        void'(q.pop_front());
        exp_dlv = exp_dlv + 4'd1;
      end
      if (exp_rdy) q.push_back({say_meth, say_v});
      $display("stream: cyc=%0d en=%b push=%b pop=%b", i, rule_enable, exp_rdy, exp_ena);
      tick();
    end
    say__ENA = 1'b0;
    for (int c = 0; c < 20 && q.size() != 0; c++) begin
      rule_enable = ((c % 2) == 0);
      #1;
      exp_ena = rule_enable;
      checks++; if (ind_heard__ENA !== exp_ena) begin errors++; $display("FAIL stream_drain_ena[%0d] got=%b exp=%b", c, ind_heard__ENA, exp_ena); end
      if (exp_ena) begin
        checks++; if ({ind_heard_heard_meth, ind_heard_heard_v} !== q[0]) begin errors++; $display("FAIL stream_drain_data[%0d] got meth=%0d exp meth=%0d", c, ind_heard_heard_meth, q[0][2*WIDTH-1:WIDTH]); end
        void'(q.pop_front());
        exp_dlv = exp_dlv + 4'd1;
      end
      tick();
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL stream_drain_timeout left=%0d exp=0", q.size()); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_count got=%0d exp=0", count); end
    checks++; if (delivered !== exp_dlv) begin errors++; $display("FAIL stream_delivered got=%0d exp=%0d", delivered, exp_dlv); end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      say__ENA = 1'b1; say_meth = WIDTH'(70 + i); say_v = WIDTH'(80 + i);
      tick();
    end
    say__ENA = 1'b0;
    #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL rstmid_count3 got=%0d exp=3", count); end
    rule_enable = 1'b1; ind_heard__RDY = 1'b1;
    nRST = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", count); end
    checks++; if (delivered !== 4'd0) begin errors++; $display("FAIL rstmid_delivered got=%0d exp=0", delivered); end
    checks++; if (say__RDY !== 1'b0) begin errors++; $display("FAIL rstmid_rdy got=%b exp=0", say__RDY); end
    checks++; if (ind_heard__ENA !== 1'b0) begin errors++; $display("FAIL rstmid_ena got=%b exp=0", ind_heard__ENA); end
    tick();
    nRST = 1'b1;
    tick();
    checks++; if (say__RDY !== 1'b1) begin errors++; $display("FAIL rstmid_rdy_after got=%b exp=1", say__RDY); end
    checks++; if (ind_heard__ENA !== 1'b0) begin errors++; $display("FAIL rstmid_stale1 got=%b exp=0", ind_heard__ENA); end
    tick();
    checks++; if (ind_heard__ENA !== 1'b0) begin errors++; $display("FAIL rstmid_stale2 got=%b exp=0", ind_heard__ENA); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_count_after got=%0d exp=0", count); end
    $display("reset_mid: count=%0d delivered=%0d", count, delivered);
  endtask

  task automatic test_wrap();
    rule_enable = 1'b1; ind_heard__RDY = 1'b1;
    for (int i = 0; i < 17; i++) begin
      say__ENA = 1'b1; say_meth = WIDTH'(200 + i); say_v = WIDTH'(300 + i);
      tick();
    end
    say__ENA = 1'b0;
    checks++; if (delivered !== 4'd0) begin errors++; $display("FAIL wrap_at16 got=%0d exp=0", delivered); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL wrap_count1 got=%0d exp=1", count); end
    tick();
    checks++; if (delivered !== 4'd1) begin errors++; $display("FAIL wrap_at17 got=%0d exp=1", delivered); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_count0 got=%0d exp=0", count); end
    $display("wrap: delivered=%0d", delivered);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_full_respond();
    test_stream();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ivector_queue.md
IVECTOR_QUEUE -- requirements
Module: ivector_queue

Interface
REQ-001 Parameter WIDTH, default 192, SHALL set the bit width of each of the two payload fields, meth and v.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of queue entries; legal values are powers of two, 2 to 64.
REQ-003 Parameter CNTW, default 16, SHALL set the width of the delivered-message counter.
REQ-004 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 nRST  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 say__ENA  input  1  SHALL be the request strobe.
REQ-007 say_meth  input  WIDTH  SHALL be request field meth.
REQ-008 say_v  input  WIDTH  SHALL be request field v.
REQ-009 say__RDY  output  1  SHALL indicate that a request can be accepted.
REQ-010 ind$heard__ENA  output  1  SHALL be the indication strobe.
REQ-011 ind$heard_heard_meth  output  WIDTH  SHALL carry the meth field of the indication.
REQ-012 ind$heard_heard_v  output  WIDTH  SHALL carry the v field of the indication.
REQ-013 ind$heard__RDY  input  1  SHALL indicate that the consumer accepts an indication.
REQ-014 rule_enable  input  1  SHALL be the scheduler enable for the respond rule.
REQ-015 rule_ready  output  1  SHALL be the respond-rule guard.
REQ-016 count  output  log2(DEPTH)+1  SHALL give the current queue occupancy.
REQ-017 delivered  output  CNTW  SHALL give the number of indications delivered.

Function
REQ-018 say__RDY SHALL equal (count != DEPTH) and SHALL be driven combinationally from registered state only.
REQ-019 Enqueue SHALL occur on a cycle where say__ENA && say__RDY: {say_meth, say_v} is written at the tail, and the tail pointer advances modulo DEPTH.
REQ-020 say__ENA asserted while say__RDY=0 SHALL be ignored, with no state change.
REQ-021 rule_ready SHALL equal (count != 0) && ind$heard__RDY.
REQ-022 The respond rule SHALL fire when rule_enable && rule_ready; ind$heard__ENA SHALL equal that fire condition.
REQ-023 The indication data outputs SHALL present the head entry combinationally whenever count != 0, and SHALL be 0 when empty.
REQ-024 A respond fire SHALL advance the head pointer modulo DEPTH and increment delivered by 1, wrapping from 2^CNTW-1 to 0.
REQ-025 Latency SHALL be one cycle: an entry enqueued in cycle N is deliverable no earlier than cycle N+1; there is no same-cycle bypass.
REQ-026 When enqueue and respond occur in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-027 When full, say__RDY SHALL stay 0 even if a respond fires that cycle; the freed slot becomes visible in the next cycle.
REQ-028 When count = 1 and a respond fires without an enqueue, ind$heard__ENA SHALL be 0 in the next cycle.
REQ-029 Entries SHALL be delivered in strict FIFO order, with meth and v kept paired.

Reset
REQ-030 While nRST=0, independent of CLK, head, tail, count and delivered SHALL be 0.
REQ-031 During reset, say__RDY SHALL be 0 and ind$heard__ENA SHALL be 0.
REQ-032 Queue storage SHALL NOT require reset.
REQ-033 Reset asserted mid-operation SHALL discard all queued entries, with no indication after release until a new enqueue.
REQ-034 After release, say__RDY SHALL rise in the first cycle.

Verification
REQ-035 Reset, then enqueue meth=1/v=2, with rule_enable=1 and ind$heard__RDY=1 -> the next cycle shows ind$heard__ENA=1, meth=1, v=2; afterwards delivered=1 and count=0.
REQ-036 With DEPTH=4 and ind$heard__RDY=0, enqueue 5 times back-to-back -> the first 4 are accepted, say__RDY=0 at count=4, and the 5th is ignored.
REQ-037 From full, enqueue and respond attempted together -> respond fires, the enqueue is refused, and count becomes 3; the next cycle accepts the enqueue and count returns to 4.
REQ-038 Steady stream with rule_enable toggling each cycle -> delivery happens only on enabled cycles and in order, with no loss or duplication.
REQ-039 With CNTW=4, deliver 17 messages -> delivered wraps to 1.
REQ-040 Assert nRST mid-stream at count=3 -> count=0 and delivered=0 immediately; no stale indication after release.
